pipe_stage_latch: RTL

Parametrised inter-stage pipeline register for the MIPS datapath, the general successor to the fixed ID/EX latch. It carries a packed control word and `NUM_CH` data channels through `STAGES` chained register slots. It adds a per-slot valid bit, stall (hold), flush (bubble injection) and bubble collapsing. Instantiated between ID/EX, EX/MEM and MEM/WB, and wherever extra retiming slots are needed.

---
 rtl/pipe_stage_latch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// pipe_stage_latch
//   General inter-stage pipeline register for the MIPS datapath. It carries a
//   packed control word and NUM_CH data channels through STAGES chained slots.
//   Each slot has its own valid bit. The block supports stall (hold), flush
//   (bubble injection) and bubble collapsing.
//   All slots update on the falling edge of clk.
//
//   Optional build macro: PIPE_LATCH_STATS_EN
//     When defined, saturating stall and bubble statistics counters are built.
//     When undefined, stall_cnt and bubble_cnt are tied to zero.
//
// Ports
//   clk         pipeline clock (falling-edge active)
//   reset       asynchronous, active-high
//   in_valid    upstream entry is a real instruction
//   in_ctrl     upstream control word
//   in_data     packed channels, channel k at [k*DATA_W +: DATA_W]
//   stall       downstream cannot take the last slot this cycle
//   flush       squash every slot
//   in_ready    slot 0 loads at the next falling edge
//   out_valid   valid bit of the last slot
//   out_ctrl    control word of the last slot
//   out_data    data of the last slot
//   stall_cnt   cycles the last slot was valid but stalled
//   bubble_cnt  cycles the last slot was empty
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_stage_latch #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 24,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int PAY_W = NUM_CH * DATA_W;

  logic [STAGES-1:0] valid_r;
  logic [CTRL_W-1:0] ctrl_r [STAGES];
  logic [PAY_W-1:0]  data_r [STAGES];

  logic [STAGES-1:0] adv_s;
  logic              adv_acc_s;
  logic [STAGES-1:0] src_valid_s;
  logic [CTRL_W-1:0] src_ctrl_s [STAGES];
  logic [PAY_W-1:0]  src_data_s [STAGES];

  // Advance chain, evaluated from the output side backwards. An empty slot
  // may always advance, which is what squeezes bubbles out behind a stall.
  always_comb begin
    adv_s = {STAGES{1'b0}};
    adv_acc_s = !stall || !valid_r[STAGES-1];
    adv_s[STAGES-1] = adv_acc_s;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv_acc_s = !valid_r[i] || adv_acc_s;
      adv_s[i] = adv_acc_s;
    end
  end

  // Load source for each slot: the ports for slot 0, otherwise the upstream slot.
  always_comb begin
    src_valid_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      src_ctrl_s[i] = {CTRL_W{1'b0}};
      src_data_s[i] = {PAY_W{1'b0}};
    end
    src_valid_s[0] = in_valid;
    src_ctrl_s[0]  = in_ctrl;
    src_data_s[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_valid_s[i] = valid_r[i-1];
      src_ctrl_s[i]  = ctrl_r[i-1];
      src_data_s[i]  = data_r[i-1];
    end
  end

  // Slot registers. Flush beats stall and advance and keeps data. A bubble
  // that loads into a slot always carries an all-zero control word.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= 1'b0;
        ctrl_r[i]  <= {CTRL_W{1'b0}};
        data_r[i]  <= {PAY_W{1'b0}};
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= 1'b0;
        ctrl_r[i]  <= {CTRL_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv_s[i]) begin
          valid_r[i] <= src_valid_s[i];
          ctrl_r[i]  <= src_valid_s[i] ? src_ctrl_s[i] : {CTRL_W{1'b0}};
          data_r[i]  <= src_data_s[i];
        end
      end
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = valid_r[STAGES-1];
  assign out_ctrl  = ctrl_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];

`ifdef PIPE_LATCH_STATS_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating statistics. Only reset clears them; flush does not.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall && valid_r[STAGES-1] && !flush) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (!valid_r[STAGES-1]) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule
